// File: rtl/ex_hilo_mdu.sv
// ex_hilo_mdu: execute-stage multiply/divide unit holding the HI/LO registers
module ex_hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [7:0]       aluop_i,
  input  logic [WIDTH-1:0] reg1_i,
  input  logic [WIDTH-1:0] reg2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] mf_data_o
);
  localparam logic [7:0] OP_MFHI  = 8'b00010000;
  localparam logic [7:0] OP_MTHI  = 8'b00010001;
  localparam logic [7:0] OP_MFLO  = 8'b00010010;
  localparam logic [7:0] OP_MTLO  = 8'b00010011;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, dvd, dvs, rem, a_abs, b_abs;
  logic neg_q, neg_r, dz, is_sdiv, is_div, zero_div, sgn_mul, ge;
  logic [2*WIDTH-1:0] mul;
  logic [WIDTH:0] r_sh, diff;
  assign is_sdiv = aluop_i == OP_DIV;
  assign is_div = valid_i && (is_sdiv || aluop_i == OP_DIVU);
  assign zero_div = reg2_i == '0;
  assign a_abs = is_sdiv && reg1_i[WIDTH-1] ? -reg1_i : reg1_i;
  assign b_abs = is_sdiv && reg2_i[WIDTH-1] ? -reg2_i : reg2_i;
  assign sgn_mul = aluop_i == OP_MULT;
  // one 2W-bit multiplier: sign-extending the operands gives the signed product in the low 2W bits
  assign mul = {{WIDTH{sgn_mul & reg1_i[WIDTH-1]}}, reg1_i} * {{WIDTH{sgn_mul & reg2_i[WIDTH-1]}}, reg2_i};
  assign r_sh = {rem, dvd[WIDTH-1]};
  assign diff = r_sh - {1'b0, dvs};
  assign ge = !diff[WIDTH];
  assign busy_o = state != IDLE;
  assign hi_o = hi;
  assign lo_o = lo;
  assign mf_data_o = aluop_i == OP_MFHI ? hi : aluop_i == OP_MFLO ? lo : '0;
  // divider state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state and stall; flush annuls whatever sits in EX
  always_comb begin
    state_nx = flush_i ? IDLE
             : state == IDLE ? (is_div ? (zero_div ? DONE : DIV) : IDLE)
             : state == DIV ? (cnt == CW'(WIDTH - 1) ? DONE : DIV)
             : IDLE;
    stall_o = !flush_i && (state == DIV || (state == IDLE && is_div));
  end
  // HI/LO writes and the restoring divider datapath; the quotient shifts into dvd
  always_ff @(posedge clk)
    if (rst) begin
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else if (!flush_i)
      case (state)
        IDLE: if (valid_i) begin
          if (aluop_i == OP_MULT || aluop_i == OP_MULTU) {hi, lo} <= mul;
          if (aluop_i == OP_MTHI) hi <= reg1_i;
          if (aluop_i == OP_MTLO) lo <= reg1_i;
          if (is_div) begin
            dz <= zero_div;
            cnt <= '0;
            rem <= zero_div ? reg1_i : '0;
            dvd <= zero_div ? '1 : a_abs;
            dvs <= b_abs;
            neg_q <= is_sdiv && (reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1]);
            neg_r <= is_sdiv && reg1_i[WIDTH-1];
          end
        end
        DIV: begin
          rem <= ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          lo <= neg_q && !dz ? -dvd : dvd;
          hi <= neg_r && !dz ? -rem : rem;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_ex_hilo_mdu.sv
// tb_ex_hilo_mdu: randomized and directed checks of ex_hilo_mdu against an arithmetic model
module tb_ex_hilo_mdu;
  localparam logic [7:0] OP_MFHI  = 8'b00010000;
  localparam logic [7:0] OP_MTHI  = 8'b00010001;
  localparam logic [7:0] OP_MFLO  = 8'b00010010;
  localparam logic [7:0] OP_MTLO  = 8'b00010011;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0, flush_i = 1'b0;
  logic [7:0] aluop_i = 8'h00;
  logic [31:0] reg1_i = '0, reg2_i = '0;
  logic stall_o, busy_o;
  logic [31:0] hi_o, lo_o, mf_data_o;
  logic [31:0] m_hi, m_lo;
  int n_cmp = 0, n_bad = 0;

  ex_hilo_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o), .mf_data_o(mf_data_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_update(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    longint unsigned up;
    if (op == OP_MULT) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      {m_hi, m_lo} = sp;
    end else if (op == OP_MULTU) begin
      up = longint'({32'h0, a}) * longint'({32'h0, b});
      {m_hi, m_lo} = up;
    end else if (op == OP_MTHI) m_hi = a;
    else if (op == OP_MTLO) m_lo = a;
    else if ((op == OP_DIV || op == OP_DIVU) && b == 0) begin
      m_lo = 32'hFFFFFFFF;
      m_hi = a;
    end else if (op == OP_DIV) begin
      sp = longint'($signed(a)) / longint'($signed(b));
      m_lo = 32'(sp);
      sp = longint'($signed(a)) % longint'($signed(b));
      m_hi = 32'(sp);
    end else if (op == OP_DIVU) begin
      m_lo = a / b;
      m_hi = a % b;
    end
  endfunction

  task automatic sc_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_mf;
    valid_i = 1'b1;
    aluop_i = op;
    reg1_i = a;
    reg2_i = b;
    exp_mf = op == OP_MFHI ? m_hi : op == OP_MFLO ? m_lo : 32'h0;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_bad++;
      $display("FAIL sc_stall op=%h got=%b want=0", op, stall_o);
    end
    n_cmp++;
    if (mf_data_o !== exp_mf) begin
      n_bad++;
      $display("FAIL sc_mf op=%h got=%h want=%h", op, mf_data_o, exp_mf);
    end
    step;
    ref_update(op, a, b);
    n_cmp++;
    if (hi_o !== m_hi || lo_o !== m_lo) begin
      n_bad++;
      $display("FAIL sc_hilo op=%h a=%h b=%h got=%h_%h want=%h_%h", op, a, b, hi_o, lo_o, m_hi, m_lo);
    end
  endtask

  task automatic div_txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int n, exp_n;
    exp_n = b == 0 ? 1 : 33;
    valid_i = 1'b1;
    aluop_i = op;
    reg1_i = a;
    reg2_i = b;
    n = 0;
    #1;
    while (stall_o === 1'b1 && n < 100) begin
      step;
      n++;
      valid_i = 1'($urandom);
      aluop_i = 8'($urandom);
      reg1_i = $urandom;
      reg2_i = $urandom;
    end
    n_cmp++;
    if (n != exp_n) begin
      n_bad++;
      $display("FAIL div_stall_cycles op=%h a=%h b=%h got=%0d want=%0d", op, a, b, n, exp_n);
    end
    n_cmp++;
    if (busy_o !== 1'b1 || stall_o !== 1'b0) begin
      n_bad++;
      $display("FAIL div_done_state busy=%b stall=%b want busy=1 stall=0", busy_o, stall_o);
    end
    valid_i = 1'b0;
    step;
    ref_update(op, a, b);
    n_cmp++;
    if (hi_o !== m_hi || lo_o !== m_lo || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL div_result op=%h a=%h b=%h got=%h_%h busy=%b want=%h_%h busy=0", op, a, b, hi_o, lo_o, busy_o, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    valid_i = 1'b0;
    step;
    step;
    rst = 1'b0;
    aluop_i = OP_MFLO;
    m_hi = 0;
    m_lo = 0;
    #1;
    n_cmp++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_hilo got=%h_%h want=0_0", hi_o, lo_o);
    end
    n_cmp++;
    if (stall_o !== 1'b0 || busy_o !== 1'b0 || mf_data_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_ctl stall=%b busy=%b mf=%h want 0 0 0", stall_o, busy_o, mf_data_o);
    end
  endtask

  task automatic test_mult;
    sc_op(OP_MULT, 32'hFFFFFFFE, 32'd3);
    n_cmp++;
    if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFA) begin
      n_bad++;
      $display("FAIL mult_const got=%h_%h want=ffffffff_fffffffa", hi_o, lo_o);
    end
    sc_op(OP_MULTU, 32'hFFFFFFFE, 32'd3);
    n_cmp++;
    if (hi_o !== 32'h2 || lo_o !== 32'hFFFFFFFA) begin
      n_bad++;
      $display("FAIL multu_const got=%h_%h want=00000002_fffffffa", hi_o, lo_o);
    end
  endtask

  task automatic test_div;
    div_txn(OP_DIV, 32'hFFFFFFF9, 32'd2);
    n_cmp++;
    if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFD) begin
      n_bad++;
      $display("FAIL div_neg7_2 got=%h_%h want=ffffffff_fffffffd", hi_o, lo_o);
    end
    div_txn(OP_DIVU, 32'd7, 32'd2);
    n_cmp++;
    if (hi_o !== 32'd1 || lo_o !== 32'd3) begin
      n_bad++;
      $display("FAIL divu_7_2 got=%h_%h want=1_3", hi_o, lo_o);
    end
    div_txn(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    n_cmp++;
    if (hi_o !== 32'h0 || lo_o !== 32'h80000000) begin
      n_bad++;
      $display("FAIL div_overflow got=%h_%h want=0_80000000", hi_o, lo_o);
    end
  endtask

  task automatic test_div_zero;
    div_txn(OP_DIVU, 32'd5, 32'd0);
    n_cmp++;
    if (hi_o !== 32'd5 || lo_o !== 32'hFFFFFFFF) begin
      n_bad++;
      $display("FAIL divu_by_zero got=%h_%h want=5_ffffffff", hi_o, lo_o);
    end
    div_txn(OP_DIV, 32'hFFFFFFF0, 32'd0);
  endtask

  task automatic test_flush;
    sc_op(OP_MTHI, 32'h11112222, 32'h0);
    sc_op(OP_MTLO, 32'h33334444, 32'h0);
    valid_i = 1'b1;
    aluop_i = OP_MULT;
    reg1_i = 32'd9;
    reg2_i = 32'd9;
    flush_i = 1'b1;
    step;
    flush_i = 1'b0;
    n_cmp++;
    if (hi_o !== m_hi || lo_o !== m_lo) begin
      n_bad++;
      $display("FAIL flush_mult got=%h_%h want=%h_%h", hi_o, lo_o, m_hi, m_lo);
    end
    aluop_i = OP_DIV;
    reg1_i = 32'd100;
    reg2_i = 32'd7;
    step;
    valid_i = 1'b0;
    for (int i = 0; i < 9; i++) step;
    n_cmp++;
    if (stall_o !== 1'b1 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_pre stall=%b busy=%b want 1 1", stall_o, busy_o);
    end
    flush_i = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_stall got=%b want=0", stall_o);
    end
    step;
    flush_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || hi_o !== m_hi || lo_o !== m_lo) begin
      n_bad++;
      $display("FAIL flush_abort busy=%b got=%h_%h want busy=0 %h_%h", busy_o, hi_o, lo_o, m_hi, m_lo);
    end
    div_txn(OP_DIVU, 32'd100, 32'd7);
    n_cmp++;
    if (hi_o !== 32'd2 || lo_o !== 32'd14) begin
      n_bad++;
      $display("FAIL flush_redo got=%h_%h want=2_14", hi_o, lo_o);
    end
  endtask

  task automatic test_back_to_back;
    sc_op(OP_MTHI, 32'h1234, 32'h0);
    sc_op(OP_MFHI, 32'h0, 32'h0);
    n_cmp++;
    if (hi_o !== 32'h1234) begin
      n_bad++;
      $display("FAIL b2b_mthi got=%h want=00001234", hi_o);
    end
    sc_op(OP_MTLO, 32'hABCD, 32'h0);
    sc_op(OP_MULT, 32'd2, 32'd3);
    n_cmp++;
    if (hi_o !== 32'h0 || lo_o !== 32'd6) begin
      n_bad++;
      $display("FAIL b2b_mult got=%h_%h want=0_6", hi_o, lo_o);
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset_abort;
    valid_i = 1'b1;
    aluop_i = OP_DIVU;
    reg1_i = 32'd1000;
    reg2_i = 32'd3;
    step;
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    m_hi = 0;
    m_lo = 0;
    n_cmp++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_abort busy=%b stall=%b got=%h_%h want 0 0 0_0", busy_o, stall_o, hi_o, lo_o);
    end
  endtask

  task automatic test_random;
    logic [7:0] ops [9];
    logic [7:0] op;
    logic [31:0] a, b;
    ops = '{OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO, OP_DIV, OP_DIVU, 8'h00};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(8)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(7) == 0) b = 32'h0;
      if ($urandom_range(15) == 0) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      if ($urandom_range(3) == 0) b = b >> $urandom_range(31);
      if (op == OP_DIV || op == OP_DIVU) div_txn(op, a, b);
      else sc_op(op, a, b);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_flush;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_hilo_mdu.md
Name: ex_hilo_mdu

Overview:
- Execute-stage multiply/divide unit with the architectural HI/LO registers.
- Consumes aluop/reg1/reg2 from the decode stage through the ID/EX register.
- Performs MULT/MULTU, MTHI/MTLO, MFHI/MFLO and an iterative DIV/DIVU.
- Raises stall_o so upstream pipeline registers hold the divide in EX until it completes.

Parameters:
WIDTH, 32, operand/HI/LO width; the divider runs WIDTH iterations.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
valid_i  input  1  EX holds a real instruction this cycle (0 = bubble)
aluop_i  input  8  op code from defines.v: EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_MFHI_OP, EXE_MFLO_OP; other codes ignored. EXE_DIV_OP/EXE_DIVU_OP are new defines.
reg1_i  input  WIDTH  rs operand / dividend / MT source
reg2_i  input  WIDTH  rt operand / divisor
flush_i  input  1  annul the instruction in EX
stall_o  output  1  hold IF/ID/EX; combinational
busy_o  output  1  divider state != IDLE
hi_o  output  WIDTH  HI register
lo_o  output  WIDTH  LO register
mf_data_o  output  WIDTH  MFHI result = hi_o; MFLO result = lo_o; 0 for any other op

Behaviour:
Reset and flush
- rst: HI=LO=0, state IDLE, counter 0, stall_o=0, busy_o=0. Reset mid-divide aborts it with no HI/LO write.
- flush_i has priority below rst and above everything else.
  - Forces stall_o=0 combinationally.
  - At the edge: state goes to IDLE and no HI/LO write occurs.

Single-cycle ops (state IDLE, valid_i=1, no flush)
- MULT: {HI,LO} <= signed reg1_i*reg2_i, full 2*WIDTH product.
- MULTU: {HI,LO} <= unsigned product.
- MTHI: HI <= reg1_i; MTLO: LO <= reg1_i.
- All writes land at the end of the EX cycle; the following instruction sees the new value.
- MFHI/MFLO: combinational read of the current registers, no write. stall_o=0.

Divide FSM (IDLE, DIV, DONE)
- IDLE, valid div op, reg2_i!=0:
  - stall_o=1.
  - Latch |dividend| and |divisor| (DIVU: raw values), plus the sign of the dividend and sign(dividend) XOR sign(divisor).
  - Clear the partial remainder; counter=0; next state DIV.
- IDLE, valid div op, reg2_i==0:
  - stall_o=1.
  - Latch quotient=all-ones and remainder=reg1_i; next state DONE.
- DIV:
  - stall_o=1.
  - One restoring shift-subtract step per cycle, MSB-first.
  - counter increments; after the step with counter==WIDTH-1, next state DONE.
- DONE:
  - stall_o=0.
  - At the edge: LO <= quotient and HI <= remainder, then IDLE.
  - Signed fix-up: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Fix-up is skipped for divide-by-zero.
- Latency (normal divide): 1 IDLE cycle + WIDTH DIV cycles with stall_o=1, then 1 DONE cycle. That is 33 stalled cycles, and the result is visible on the cycle after DONE.
- Latency (divide-by-zero): 1 stalled cycle, then DONE.
- Operands are taken from the latched copies only; reg1_i/reg2_i/aluop_i changes during DIV/DONE are ignored.
- DONE commits unconditionally unless flush_i or rst.
- Signed overflow 0x80000000 / -1 wraps: LO=0x80000000, HI=0.
- Non-divide ops cannot reach the unit while busy (pipeline stalled); if presented, they are ignored.
- valid_i=0 in IDLE: no action.

Test Plan:
- Reset: assert rst for 2 cycles -> hi_o=lo_o=0, stall_o=0, busy_o=0; MFLO gives mf_data_o=0.
- MULT 0xFFFFFFFE x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA. stall_o stays 0.
- DIV -7/2 -> stall_o high exactly 33 cycles, then low 1 cycle; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: DIVU 5/0 -> stall_o high 1 cycle, then LO=0xFFFFFFFF, HI=5.
- Flush: DIV 100/7 with flush_i pulsed in the 10th DIV cycle -> stall_o=0 that cycle, state IDLE, HI/LO unchanged. A following DIVU 100/7 -> LO=14, HI=2.
- Back-to-back: MTHI 0x1234, then MFHI the next cycle -> mf_data_o=0x1234. Then MTLO 0xABCD followed by MULT 2x3 -> LO=6, HI=0, with no spurious stall.
